// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scan controller with double-buffered BCD load
module display_scan_ctrl #(
  parameter int N_DIGITS = 8,
  parameter int DRIVE_CYCLES = 100000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  blank_lz,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_data,
  input  logic [N_DIGITS-1:0]   load_dp,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [2:0]            digit_idx
);
  localparam int CW = $clog2((DRIVE_CYCLES > GAP_CYCLES ? DRIVE_CYCLES : GAP_CYCLES) + 1);
  typedef enum logic [1:0] {OFF, DRIVE, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [4*N_DIGITS-1:0] disp_data, pend_data;
  logic [N_DIGITS-1:0] disp_dp, pend_dp, an_n;
  logic pend, commit, accept, hi_zero, cur_dp;
  logic [3:0] cur;
  logic [6:0] dec;
  assign load_ready = !pend;
  assign digit_idx = idx;
  assign accept = load_valid && load_ready;
  assign commit = pend && (state == OFF || (state_n == DRIVE && state != DRIVE && idx_n == '0));
  always_comb begin
    state_n = state;
    cnt_n = '0;
    idx_n = idx;
    if (!enable) begin
      state_n = OFF;
      idx_n = '0;
    end else if (state == OFF) begin
      state_n = DRIVE;
      idx_n = '0;
    end else if (state == DRIVE) begin
      if (cnt == CW'(DRIVE_CYCLES - 1)) state_n = GAP;
      else cnt_n = cnt + CW'(1);
    end else if (cnt == CW'(GAP_CYCLES - 1)) begin
      state_n = DRIVE;
      idx_n = idx == 3'(N_DIGITS - 1) ? 3'd0 : idx + 3'd1;
    end else cnt_n = cnt + CW'(1);
  end
  always_comb begin
    cur = '0;
    cur_dp = 1'b0;
    hi_zero = 1'b1;
    an_n = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        cur = disp_data[4*i +: 4];
        cur_dp = disp_dp[i];
        an_n[i] = state != DRIVE;
      end
      if (3'(i) >= idx) hi_zero = hi_zero & (disp_data[4*i +: 4] == 4'd0);
    end
  end
  always_comb begin
    case (cur)
      4'd0: dec = 7'b0000001;
      4'd1: dec = 7'b1001111;
      4'd2: dec = 7'b0010010;
      4'd3: dec = 7'b0000110;
      4'd4: dec = 7'b1001100;
      4'd5: dec = 7'b0100100;
      4'd6: dec = 7'b0100000;
      4'd7: dec = 7'b0001111;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0000100;
      default: dec = 7'b1111111;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= OFF;
      cnt <= '0;
      idx <= '0;
      an <= '1;
      seg <= '1;
      dp <= 1'b1;
      disp_data <= '0;
      disp_dp <= '0;
      pend_data <= '0;
      pend_dp <= '0;
      pend <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      an <= an_n;
      seg <= state == DRIVE && !(blank_lz && idx != 3'd0 && hi_zero) ? dec : 7'b1111111;
      dp <= !(state == DRIVE && cur_dp);
      pend <= (pend && !commit) || accept;
      if (accept) begin
        pend_data <= load_data;
        pend_dp <= load_dp;
      end
      if (commit) begin
        disp_data <= pend_data;
        disp_dp <= pend_dp;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl with directed load/scan vectors
module tb_display_scan_ctrl;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110,
                         S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111,
                         S8 = 7'b0000000, SB = 7'b1111111;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] len;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n, enable, blank_lz, load_valid, load_ready, dp;
  logic [15:0] load_data;
  logic [3:0] load_dp, an;
  logic [6:0] seg;
  logic [2:0] digit_idx;
  int n_cmp = 0, n_bad = 0;
  obs_t exp_q[$];
  obs_t cap, got, want;
  logic mon_en = 1'b0, lit = 1'b0, stable = 1'b1;
  display_scan_ctrl #(.N_DIGITS(4), .DRIVE_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .blank_lz(blank_lz),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_dp(load_dp), .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mon_en) begin
      if (an != 4'hF) begin
        if (!lit) begin
          lit = 1'b1;
          stable = 1'b1;
          cap = {an, seg, dp, 8'd1};
        end else begin
          cap.len = cap.len + 8'd1;
          if ({an, seg, dp} != {cap.an, cap.seg, cap.dp}) stable = 1'b0;
        end
      end else if (lit) begin
        lit = 1'b0;
        got = cap;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got an=%b seg=%b dp=%b len=%0d, expected no lit digit", got.an, got.seg, got.dp, got.len);
        end else begin
          want = exp_q.pop_front();
          if (got !== want || !stable) begin
            n_bad++;
            $display("FAIL sb_digit: got an=%b seg=%b dp=%b len=%0d stable=%b, expected an=%b seg=%b dp=%b len=%0d",
                     got.an, got.seg, got.dp, got.len, stable, want.an, want.seg, want.dp, want.len);
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int l);
    obs_t o;
    o.an = a;
    o.seg = s;
    o.dp = d;
    o.len = 8'(l);
    exp_q.push_back(o);
  endtask
  task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                            input logic [6:0] s0, input logic [3:0] dpm);
    push(4'b1110, s0, !dpm[0], 4);
    push(4'b1101, s1, !dpm[1], 4);
    push(4'b1011, s2, !dpm[2], 4);
    push(4'b0111, s3, !dpm[3], 4);
  endtask
  task automatic load(input logic [15:0] d, input logic [3:0] p);
    load_data = d;
    load_dp = p;
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
    tick(1);
  endtask
  task automatic run_frames(input int k);
    enable = 1'b1;
    tick(20 * k);
    enable = 1'b0;
    tick(2);
  endtask
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    blank_lz = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    load_dp = '0;
    tick(3);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'(SB));
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    rst_n = 1'b1;
    tick(1);
    mon_en = 1'b1;
    load(16'h1234, 4'b0000);
    push_frame(S1, S2, S3, S4, 4'b0000);
    push_frame(S1, S2, S3, S4, 4'b0000);
    run_frames(2);
    chk("off_an", 32'(an), 32'hF);
    chk("off_idx", 32'(digit_idx), 32'h0);
    blank_lz = 1'b1;
    load(16'h0042, 4'b0000);
    push_frame(SB, SB, S4, S2, 4'b0000);
    run_frames(1);
    load(16'h0000, 4'b0000);
    push_frame(SB, SB, SB, S0, 4'b0000);
    run_frames(1);
    blank_lz = 1'b0;
    load(16'h00A5, 4'b0010);
    push_frame(S0, S0, SB, S5, 4'b0010);
    run_frames(1);
    load(16'h1111, 4'b0000);
    push_frame(S1, S1, S1, S1, 4'b0000);
    push_frame(S2, S2, S2, S2, 4'b0000);
    push_frame(S3, S3, S3, S3, 4'b0000);
    enable = 1'b1;
    tick(11);
    load_data = 16'h2222;
    load_valid = 1'b1;
    tick(1);
    chk("ready_after_load", 32'(load_ready), 32'h0);
    load_data = 16'h3333;
    tick(1);
    chk("ready_stall_a", 32'(load_ready), 32'h0);
    tick(7);
    chk("ready_stall_b", 32'(load_ready), 32'h0);
    tick(1);
    chk("ready_at_commit", 32'(load_ready), 32'h1);
    tick(1);
    load_valid = 1'b0;
    chk("ready_third_taken", 32'(load_ready), 32'h0);
    tick(38);
    enable = 1'b0;
    tick(2);
    push(4'b1110, S3, 1'b1, 4);
    push(4'b1101, S3, 1'b1, 4);
    push(4'b1011, S3, 1'b1, 2);
    enable = 1'b1;
    tick(3);
    load_data = 16'h5678;
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
    tick(8);
    enable = 1'b0;
    tick(1);
    chk("dis_idx", 32'(digit_idx), 32'h0);
    tick(1);
    chk("dis_an", 32'(an), 32'hF);
    chk("dis_commit_ready", 32'(load_ready), 32'h1);
    push_frame(S5, S6, S7, S8, 4'b0000);
    run_frames(1);
    push(4'b1110, S8, 1'b1, 4);
    enable = 1'b1;
    tick(3);
    load_data = 16'h9999;
    load_valid = 1'b1;
    tick(1);
    load_data = 16'h1111;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("mrst_an", 32'(an), 32'hF);
    chk("mrst_seg", 32'(seg), 32'(SB));
    chk("mrst_dp", 32'(dp), 32'h1);
    chk("mrst_idx", 32'(digit_idx), 32'h0);
    chk("mrst_ready", 32'(load_ready), 32'h1);
    tick(1);
    chk("mrst_ready_hold", 32'(load_ready), 32'h1);
    chk("mrst_an_hold", 32'(an), 32'hF);
    rst_n = 1'b1;
    enable = 1'b0;
    load_valid = 1'b0;
    tick(2);
    push_frame(S0, S0, S0, S0, 4'b0000);
    run_frames(1);
    tick(5);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
